// File: rtl/ifu_fetch_rsp_pkg.sv
// ifu_fetch_rsp_pkg
//   Shared constants and types for the IFU fetch responder slice.
//   - ANOM_PC_WIDTH      : PC width; line addresses are ANOM_PC_WIDTH-2 bits.
//   - ANOM_FETCH_DATA_W  : fetch line width.
//   - ANOM_FETCH_TMO     : default memory timeout in cycles (legal 1..255).
//   - TMO_CNT_W          : timeout counter width, wide enough for TIMEOUT=255.
//   - ifr_state_e        : responder FSM encoding, also exported for debug.
package ifu_fetch_rsp_pkg;

  localparam int ANOM_PC_WIDTH     = 30;
  localparam int ANOM_FETCH_DATA_W = 128;
  localparam int ANOM_FETCH_TMO    = 15;
  localparam int TMO_CNT_W         = 8;

  typedef enum logic [1:0] {
    IFR_IDLE  = 2'd0,
    IFR_WAIT  = 2'd1,
    IFR_DRAIN = 2'd2,
    IFR_RESP  = 2'd3
  } ifr_state_e;

endpackage

// File: rtl/ifu_fetch_rsp_if.sv
// ifu_fetch_rsp_if
//   Bundles the fetch request port, the instruction SRAM port and the
//   IDU-side response port of the fetch responder.
//
//   Handshake semantics (both valid/ready pairs):
//     A transfer happens in a cycle where valid and ready are both high at
//     the rising clock edge. The producer keeps valid and its payload stable
//     until that transfer; ready may change freely and never depends on a
//     future valid. i_Flush can withdraw the responder's o_FetchR and can
//     drop a pending response without a transfer.
//
//   Ports (slave = responder side):
//     i_FetchV/o_FetchR/i_FetchA/i_InstrSel : fetch request handshake + payload
//     i_Flush                               : jump/redirect kill
//     o_MemReq/o_MemA                       : one-cycle SRAM read strobe + address
//     i_MemV/i_MemD                         : SRAM read data return
//     o_RspV/i_RspR/o_RspD/o_RspSel/o_RspErr: response handshake + payload
interface ifu_fetch_rsp_if
  import ifu_fetch_rsp_pkg::*;
#(
  parameter int PC_WIDTH = ANOM_PC_WIDTH,
  parameter int DATA_W   = ANOM_FETCH_DATA_W
);

  logic                  i_FetchV;
  logic                  o_FetchR;
  logic [PC_WIDTH-3:0]   i_FetchA;
  logic [1:0]            i_InstrSel;
  logic                  i_Flush;
  logic                  o_MemReq;
  logic [PC_WIDTH-3:0]   o_MemA;
  logic                  i_MemV;
  logic [DATA_W-1:0]     i_MemD;
  logic                  o_RspV;
  logic [DATA_W-1:0]     o_RspD;
  logic [1:0]            o_RspSel;
  logic                  o_RspErr;
  logic                  i_RspR;

  modport slave (
    input  i_FetchV, i_FetchA, i_InstrSel, i_Flush, i_MemV, i_MemD, i_RspR,
    output o_FetchR, o_MemReq, o_MemA, o_RspV, o_RspD, o_RspSel, o_RspErr
  );

  modport master (
    output i_FetchV, i_FetchA, i_InstrSel, i_Flush, i_MemV, i_MemD, i_RspR,
    input  o_FetchR, o_MemReq, o_MemA, o_RspV, o_RspD, o_RspSel, o_RspErr
  );

endinterface

// File: rtl/ifu_fetch_tmo_cnt.sv
// ifu_fetch_tmo_cnt
//   Saturating memory-timeout counter.
//   Ports:
//     i_Clk, i_Rst : clock, asynchronous active-high reset
//     i_Clr        : load zero (wins over i_En)
//     i_En         : count up by one, holding at TIMEOUT
//     o_Expired    : count has reached TIMEOUT
//   TIMEOUT must lie in 1..255 so it fits the 8-bit count.
module ifu_fetch_tmo_cnt
  import ifu_fetch_rsp_pkg::*;
#(
  parameter int TIMEOUT = ANOM_FETCH_TMO
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Clr,
  input  logic i_En,
  output logic o_Expired
);

  localparam logic [TMO_CNT_W-1:0] LIMIT = TMO_CNT_W'(TIMEOUT);

  logic [TMO_CNT_W-1:0] count;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      count <= '0;
    end else if (i_Clr) begin
      count <= '0;
    end else if (i_En && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign o_Expired = (count == LIMIT);

endmodule

// File: rtl/ifu_fetch_rsp.sv
// ifu_fetch_rsp
//   Responder end of the IFU fetch request interface. Accepts one line
//   request at a time, issues a single-cycle SRAM read, waits for the data
//   (bounded by TIMEOUT cycles) and returns the line with its select tag on
//   a valid/ready response port. A flush kills the in-flight fetch; memory
//   data still owed after a flush is drained and discarded.
//   Ports:
//     i_Clk, i_Rst : clock, asynchronous active-high reset
//     bus          : ifu_fetch_rsp_if slave (request, SRAM and response ports)
//     o_State      : current FSM state, for debug/observation
module ifu_fetch_rsp
  import ifu_fetch_rsp_pkg::*;
#(
  parameter int PC_WIDTH = ANOM_PC_WIDTH,
  parameter int DATA_W   = ANOM_FETCH_DATA_W,
  parameter int TIMEOUT  = ANOM_FETCH_TMO
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  ifu_fetch_rsp_if.slave      bus,
  output ifr_state_e          o_State
);

  ifr_state_e            state;
  logic                  memReq;
  logic [PC_WIDTH-3:0]   memA;
  logic                  rspV;
  logic [DATA_W-1:0]     rspD;
  logic [1:0]            rspSel;
  logic                  rspErr;
  logic [1:0]            selQ;

  logic                  fetchR;
  logic                  accept;
  logic                  cntEn;
  logic                  expired;

  // Ready is combinational so that a flush or reset blocks acceptance in
  // the very cycle it is seen.
  assign fetchR = (state == IFR_IDLE) & ~bus.i_Flush & ~i_Rst;
  assign accept = bus.i_FetchV & fetchR;

  // The counter runs while memory data is owed, including after a flush,
  // so a drain can never wait forever on a lost response.
  assign cntEn = (state == IFR_WAIT) | (state == IFR_DRAIN);

  ifu_fetch_tmo_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_Clr     (accept),
    .i_En      (cntEn),
    .o_Expired (expired)
  );

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state  <= IFR_IDLE;
      memReq <= 1'b0;
      memA   <= '0;
      rspV   <= 1'b0;
      rspD   <= '0;
      rspSel <= 2'b00;
      rspErr <= 1'b0;
      selQ   <= 2'b00;
    end else begin
      memReq <= 1'b0;
      case (state)
        IFR_IDLE: begin
          if (accept) begin
            memA   <= bus.i_FetchA;
            selQ   <= bus.i_InstrSel;
            memReq <= 1'b1;
            state  <= IFR_WAIT;
          end
        end
        IFR_WAIT: begin
          if (bus.i_Flush) begin
            // Data arriving with the flush settles the debt; otherwise drain.
            state <= bus.i_MemV ? IFR_IDLE : IFR_DRAIN;
          end else if (bus.i_MemV) begin
            rspD   <= bus.i_MemD;
            rspErr <= 1'b0;
            rspSel <= selQ;
            rspV   <= 1'b1;
            state  <= IFR_RESP;
          end else if (expired) begin
            rspD   <= '0;
            rspErr <= 1'b1;
            rspSel <= selQ;
            rspV   <= 1'b1;
            state  <= IFR_RESP;
          end
        end
        IFR_DRAIN: begin
          if (bus.i_MemV || expired) begin
            state <= IFR_IDLE;
          end
        end
        IFR_RESP: begin
          // Payload holds until the consumer takes it or a flush drops it.
          if (bus.i_Flush || bus.i_RspR) begin
            rspV   <= 1'b0;
            rspErr <= 1'b0;
            state  <= IFR_IDLE;
          end
        end
        default: state <= IFR_IDLE;
      endcase
    end
  end

  assign bus.o_FetchR = fetchR;
  assign bus.o_MemReq = memReq;
  assign bus.o_MemA   = memA;
  assign bus.o_RspV   = rspV;
  assign bus.o_RspD   = rspD;
  assign bus.o_RspSel = rspSel;
  assign bus.o_RspErr = rspErr;
  assign o_State      = state;

endmodule

// File: tb/tb_ifu_fetch_rsp.sv
// tb_ifu_fetch_rsp
//   Bench for ifu_fetch_rsp: directed scenarios with literal expectations,
//   then randomized traffic, all checked every cycle against a
//   transaction-level reference model.
module tb_ifu_fetch_rsp;
  import ifu_fetch_rsp_pkg::*;

  localparam int PCW = ANOM_PC_WIDTH;
  localparam int DW  = ANOM_FETCH_DATA_W;
  localparam int TMO = ANOM_FETCH_TMO;
  localparam int W   = DW + 3;

  // ---------------- clock / reset ----------------
  logic i_Clk = 1'b0;
  logic i_Rst;
  always #5 i_Clk = ~i_Clk;

  ifu_fetch_rsp_if #(.PC_WIDTH(PCW), .DATA_W(DW)) bus ();
  ifr_state_e dbg_state;

  ifu_fetch_rsp #(.PC_WIDTH(PCW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .bus     (bus),
    .o_State (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- reference model ----------------
  // A fetch is "busy" from acceptance until the responder is free again.
  // While memory data is owed, m_elapsed counts cycles since the read strobe
  // cycle; it times out once m_elapsed reaches TMO. A flush before the
  // result turns the fetch into one that is not delivered. The expected
  // response (if any) sits at the head of exp_q as {err, sel, data}.
  logic [W-1:0] exp_q[$];
  bit           m_busy, m_owed, m_deliver, m_memreq;
  int           m_elapsed;
  logic [PCW-3:0] m_mema;
  logic [1:0]   m_sel;

  always @(negedge i_Clk) begin
    logic [W-1:0] e;
    bit resolved;
    if (i_Rst) begin
      chk("rst_fetch_r", DW'(bus.o_FetchR), '0);
      chk("rst_mem_req", DW'(bus.o_MemReq), '0);
      chk("rst_rsp_v",   DW'(bus.o_RspV), '0);
      chk("rst_rsp_err", DW'(bus.o_RspErr), '0);
      exp_q.delete();
      m_busy = 0; m_owed = 0; m_deliver = 0; m_memreq = 0; m_elapsed = 0;
    end else begin
      // compare
      chk("fetch_r", DW'(bus.o_FetchR), DW'(!m_busy && !bus.i_Flush));
      chk("mem_req", DW'(bus.o_MemReq), DW'(m_memreq));
      if (m_memreq) chk("mem_a", DW'(bus.o_MemA), DW'(m_mema));
      chk("rsp_v", DW'(bus.o_RspV), DW'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk("rsp_d",   bus.o_RspD, e[DW-1:0]);
        chk("rsp_sel", DW'(bus.o_RspSel), DW'(e[DW+1:DW]));
        chk("rsp_err", DW'(bus.o_RspErr), DW'(e[DW+2]));
      end else begin
        chk("rsp_err_idle", DW'(bus.o_RspErr), '0);
      end
      // advance
      m_memreq = 0;
      if (!m_busy) begin
        if (bus.i_FetchV && !bus.i_Flush) begin
          m_busy = 1; m_owed = 1; m_deliver = 1; m_elapsed = 0;
          m_mema = bus.i_FetchA; m_sel = bus.i_InstrSel; m_memreq = 1;
        end
      end else if (m_owed) begin
        resolved = bus.i_MemV || (m_elapsed >= TMO);
        if (!m_deliver) begin
          if (resolved) begin m_busy = 0; m_owed = 0; end
        end else if (bus.i_Flush) begin
          if (bus.i_MemV) begin m_busy = 0; m_owed = 0; end
          else m_deliver = 0;
        end else if (resolved) begin
          m_owed = 0;
          if (bus.i_MemV) exp_q.push_back({1'b0, m_sel, bus.i_MemD});
          else            exp_q.push_back({1'b1, m_sel, {DW{1'b0}}});
        end
        m_elapsed++;
      end else begin
        if (bus.i_Flush || bus.i_RspR) begin
          void'(exp_q.pop_front());
          m_busy = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cyc();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic clr_in();
    bus.i_FetchV = 1'b0; bus.i_FetchA = '0; bus.i_InstrSel = 2'b00;
    bus.i_Flush = 1'b0;  bus.i_MemV = 1'b0;  bus.i_MemD = '0;
    bus.i_RspR = 1'b0;
  endtask

  task automatic req(input logic [PCW-3:0] a, input logic [1:0] s);
    bus.i_FetchV = 1'b1; bus.i_FetchA = a; bus.i_InstrSel = s;
  endtask

  // ---------------- stimulus ----------------
  logic [DW-1:0] d_a5, d2, d3, d4;

  initial begin
    int cd;
    d_a5 = {16{8'hA5}};
    d2 = rand_line(); d3 = rand_line(); d4 = rand_line();
    i_Rst = 1'b1;
    clr_in();
    repeat (3) next_cyc();
    @(negedge i_Clk);
    chk("reset_rsp_d",   bus.o_RspD, '0);
    chk("reset_rsp_sel", DW'(bus.o_RspSel), '0);
    chk("reset_mem_a",   DW'(bus.o_MemA), '0);
    chk("reset_state",   DW'(dbg_state), DW'(IFR_IDLE));
    next_cyc();
    i_Rst = 1'b0;

    // Basic fetch: accept T, strobe T+1, data T+3, response T+4.
    req(28'h0000123, 2'b10);
    @(negedge i_Clk); chk("t1_fetch_r_T", DW'(bus.o_FetchR), 1);
    next_cyc(); clr_in();
    @(negedge i_Clk);
    chk("t1_memreq_T1", DW'(bus.o_MemReq), 1);
    chk("t1_mema_T1", DW'(bus.o_MemA), DW'(28'h0000123));
    chk("t1_fetch_r_T1", DW'(bus.o_FetchR), 0);
    next_cyc();
    @(negedge i_Clk); chk("t1_memreq_T2", DW'(bus.o_MemReq), 0);
    next_cyc(); bus.i_MemV = 1'b1; bus.i_MemD = d_a5;
    @(negedge i_Clk); chk("t1_rsp_v_T3", DW'(bus.o_RspV), 0);
    next_cyc(); clr_in(); bus.i_RspR = 1'b1;
    @(negedge i_Clk);
    chk("t1_rsp_v_T4", DW'(bus.o_RspV), 1);
    chk("t1_rsp_d_T4", bus.o_RspD, d_a5);
    chk("t1_rsp_sel_T4", DW'(bus.o_RspSel), 2);
    chk("t1_rsp_err_T4", DW'(bus.o_RspErr), 0);
    chk("t1_fetch_r_hs", DW'(bus.o_FetchR), 0);
    next_cyc(); clr_in();
    @(negedge i_Clk);
    chk("t1_rsp_v_T5", DW'(bus.o_RspV), 0);
    chk("t1_fetch_r_T5", DW'(bus.o_FetchR), 1);

    // Backpressure with i_FetchV held high, then flush in WAIT.
    next_cyc(); req(28'h0abcdef, 2'b01);
    next_cyc();
    next_cyc();
    next_cyc(); bus.i_MemV = 1'b1; bus.i_MemD = d2;
    next_cyc(); bus.i_MemV = 1'b0; bus.i_RspR = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_Clk);
      chk("t2_hold_v", DW'(bus.o_RspV), 1);
      chk("t2_hold_d", bus.o_RspD, d2);
      chk("t2_hold_sel", DW'(bus.o_RspSel), 1);
      chk("t2_hold_fetch_r", DW'(bus.o_FetchR), 0);
      next_cyc();
    end
    bus.i_RspR = 1'b1;
    @(negedge i_Clk); chk("t2_hs_fetch_r", DW'(bus.o_FetchR), 0);
    next_cyc(); bus.i_RspR = 1'b0; req(28'h7654321, 2'b00);
    @(negedge i_Clk);
    chk("t2_after_hs_fetch_r", DW'(bus.o_FetchR), 1);
    chk("t2_after_hs_rsp_v", DW'(bus.o_RspV), 0);
    next_cyc(); clr_in();
    @(negedge i_Clk);
    chk("t4_memreq", DW'(bus.o_MemReq), 1);
    chk("t4_mema", DW'(bus.o_MemA), DW'(28'h7654321));
    next_cyc(); bus.i_Flush = 1'b1;
    next_cyc(); bus.i_Flush = 1'b0;
    next_cyc();
    next_cyc(); bus.i_MemV = 1'b1; bus.i_MemD = rand_line();
    @(negedge i_Clk); chk("t4_drain_fetch_r", DW'(bus.o_FetchR), 0);
    next_cyc(); clr_in(); req(28'h1111111, 2'b11);
    @(negedge i_Clk);
    chk("t4_free_fetch_r", DW'(bus.o_FetchR), 1);
    chk("t4_no_rsp", DW'(bus.o_RspV), 0);
    next_cyc(); clr_in();
    next_cyc();
    next_cyc(); bus.i_MemV = 1'b1; bus.i_MemD = d3;
    next_cyc(); clr_in(); bus.i_RspR = 1'b1;
    @(negedge i_Clk);
    chk("t4_next_rsp_d", bus.o_RspD, d3);
    chk("t4_next_rsp_sel", DW'(bus.o_RspSel), 3);
    next_cyc(); clr_in();

    // Timeout: strobe at T+1, counter hits TMO at T+1+TMO, response follows.
    req(28'h0000fff, 2'b10);
    next_cyc(); clr_in();
    for (int i = 1; i <= TMO + 1; i++) begin
      @(negedge i_Clk); chk("t3_no_rsp_yet", DW'(bus.o_RspV), 0);
      next_cyc();
    end
    @(negedge i_Clk);
    chk("t3_tmo_v", DW'(bus.o_RspV), 1);
    chk("t3_tmo_err", DW'(bus.o_RspErr), 1);
    chk("t3_tmo_d", bus.o_RspD, '0);
    chk("t3_tmo_sel", DW'(bus.o_RspSel), 2);
    next_cyc(); bus.i_MemV = 1'b1; bus.i_MemD = d4;
    next_cyc(); bus.i_MemV = 1'b0;
    @(negedge i_Clk);
    chk("t3_late_memv_err", DW'(bus.o_RspErr), 1);
    chk("t3_late_memv_d", bus.o_RspD, '0);
    next_cyc(); bus.i_RspR = 1'b1;
    next_cyc(); clr_in();

    // Flush in RESP, then flush in IDLE.
    req(28'h0000042, 2'b01);
    next_cyc(); clr_in();
    bus.i_MemV = 1'b1; bus.i_MemD = d4;
    next_cyc(); clr_in();
    @(negedge i_Clk); chk("t5_rsp_v", DW'(bus.o_RspV), 1);
    next_cyc(); bus.i_Flush = 1'b1;
    next_cyc(); bus.i_Flush = 1'b0;
    @(negedge i_Clk);
    chk("t5_flushed_v", DW'(bus.o_RspV), 0);
    chk("t5_state_idle", DW'(dbg_state), DW'(IFR_IDLE));
    next_cyc(); bus.i_Flush = 1'b1; req(28'h0000043, 2'b00);
    @(negedge i_Clk); chk("t5_idle_flush_fetch_r", DW'(bus.o_FetchR), 0);
    next_cyc(); clr_in();
    @(negedge i_Clk);
    chk("t5_no_memreq", DW'(bus.o_MemReq), 0);
    chk("t5_fetch_r_back", DW'(bus.o_FetchR), 1);

    // Asynchronous reset in WAIT.
    next_cyc(); req(28'h0000777, 2'b11);
    next_cyc(); clr_in();
    #1 chk("t6_memreq_before", DW'(bus.o_MemReq), 1);
    #1 i_Rst = 1'b1;
    @(negedge i_Clk);
    chk("t6_async_memreq", DW'(bus.o_MemReq), 0);
    chk("t6_async_fetch_r", DW'(bus.o_FetchR), 0);
    chk("t6_async_mema", DW'(bus.o_MemA), 0);
    next_cyc(); i_Rst = 1'b0; bus.i_MemV = 1'b1; bus.i_MemD = d4;
    @(negedge i_Clk); chk("t6_fetch_r_after", DW'(bus.o_FetchR), 1);
    next_cyc(); clr_in();
    @(negedge i_Clk); chk("t6_stale_no_rsp", DW'(bus.o_RspV), 0);
    next_cyc();

    // Randomized traffic with a memory that answers after 1..20 cycles
    // (beyond TIMEOUT at the upper end) and occasional stray i_MemV.
    cd = -1;
    for (int c = 0; c < 3000; c++) begin
      bus.i_FetchV   = ($urandom_range(0, 1) == 1);
      bus.i_FetchA   = (PCW-2)'($urandom);
      bus.i_InstrSel = 2'($urandom);
      bus.i_Flush    = ($urandom_range(0, 19) == 0);
      bus.i_RspR     = ($urandom_range(0, 2) != 0);
      if (cd > 0) cd--;
      bus.i_MemV     = (cd == 0) || ($urandom_range(0, 49) == 0);
      if (cd == 0) cd = -1;
      bus.i_MemD     = rand_line();
      @(negedge i_Clk);
      if (bus.o_MemReq) cd = $urandom_range(1, 20);
      next_cyc();
    end
    clr_in();
    next_cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
